// File: rtl/mult_pkg.sv
// Shared constants, types and helpers for the multiplier datapath and the
// frame accumulator that consumes its result stream.
//   MULT_N / MULT_M : default multiplicand / multiplier widths
//   ACC_K           : default products per accumulated frame
//   acc_width()     : accumulator width that holds K full-scale products
//   hold_state_e    : state of the accumulator's output register
package mult_pkg;

    localparam int MULT_N = 8;
    localparam int MULT_M = 4;
    localparam int ACC_K  = 4;

    // K products of (2^n-1)*(2^m-1) fit in n+m+clog2(k) bits without wrap.
    function automatic int acc_width(input int n, input int m, input int k);
        return n + m + $clog2(k);
    endfunction

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/mult_acc_hold.sv
// Output register of the frame accumulator.
// Holds one completed frame (sum + length) until the consumer acknowledges
// it. A completion that arrives while a frame is held and not being acked is
// dropped and recorded in the sticky overrun flag.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   load             : a frame completes this cycle
//   load_sum/len     : value and product count of the completing frame
//   sum_ack          : consumer takes the held frame this cycle
//   sum, frame_len   : held frame
//   state            : EMPTY/FULL; FULL is the valid indication
//   overrun          : sticky, a completed frame was dropped
//
// Handshake: the frame is offered while state is FULL and is consumed on
// any cycle where FULL and sum_ack are both high; sum_ack while EMPTY has no
// effect. There is no back-pressure toward the producer.
module mult_acc_hold
    import mult_pkg::*;
#(
    parameter int AW = 14,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_sum,
    input  logic [LW-1:0] load_len,
    input  logic          sum_ack,
    output logic [AW-1:0] sum,
    output logic [LW-1:0] frame_len,
    output hold_state_e   state,
    output logic          overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HOLD_EMPTY;
            sum       <= '0;
            frame_len <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                HOLD_EMPTY: begin
                    if (load) begin
                        sum       <= load_sum;
                        frame_len <= load_len;
                        state     <= HOLD_FULL;
                    end
                end
                HOLD_FULL: begin
                    if (sum_ack) begin
                        if (load) begin
                            // back-to-back: replace the acked frame directly
                            sum       <= load_sum;
                            frame_len <= load_len;
                        end else begin
                            // held values stay visible after the ack
                            state <= HOLD_EMPTY;
                        end
                    end else if (load) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= HOLD_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mult_acc.sv
// Frame accumulator downstream of the pipelined multiplier.
// Sums frames of K products from the res_rdy/res stream; a frame also closes
// early on flush. Completed frames are handed to mult_acc_hold.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   res_rdy    : product valid (one per clock max, cannot be stalled)
//   res        : product, N+M bits
//   flush      : close the current partial frame (includes a same-cycle product)
//   sum        : completed frame sum, AW bits
//   sum_vld    : sum/frame_len valid, held until sum_ack
//   sum_ack    : consumer accepts the held frame
//   frame_len  : number of products in sum, 1..K
//   overrun    : sticky, a completed frame was dropped
module mult_acc
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int M  = MULT_M,
    parameter int K  = ACC_K,
    parameter int AW = acc_width(N, M, K),
    parameter int LW = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          res_rdy,
    input  logic [N+M-1:0] res,
    input  logic          flush,
    output logic [AW-1:0] sum,
    output logic          sum_vld,
    input  logic          sum_ack,
    output logic [LW-1:0] frame_len,
    output logic          overrun
);

    localparam logic [LW-1:0] CNT_LAST = LW'(K - 1);

    logic [AW-1:0] acc;
    logic [LW-1:0] cnt;
    logic [AW-1:0] res_ext;
    logic [AW-1:0] acc_next;
    logic          complete;
    logic [AW-1:0] comp_sum;
    logic [LW-1:0] comp_len;
    hold_state_e   hold_state;

    assign res_ext = {{(AW - N - M){1'b0}}, res};

    // cnt==0 marks the first product of a frame: acc still holds the previous
    // frame and must be replaced, not added to.
    assign acc_next = (cnt == '0) ? res_ext : acc + res_ext;

    assign complete = (res_rdy && (cnt == CNT_LAST)) ||
                      (flush && ((cnt != '0) || res_rdy));

    assign comp_sum = res_rdy ? acc_next : acc;
    assign comp_len = cnt + {{(LW - 1){1'b0}}, res_rdy};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (res_rdy) begin
                acc <= acc_next;
            end
            if (complete) begin
                cnt <= '0;
            end else if (res_rdy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    mult_acc_hold #(
        .AW (AW),
        .LW (LW)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_sum  (comp_sum),
        .load_len  (comp_len),
        .sum_ack   (sum_ack),
        .sum       (sum),
        .frame_len (frame_len),
        .state     (hold_state),
        .overrun   (overrun)
    );

    assign sum_vld = (hold_state == HOLD_FULL);

endmodule
